// File: rtl/round_scheduler.sv
// round_scheduler: game-round sequencer driving LFSM, position load and painter handshakes; optional MISS_PENALTY_EN makes a miss cost one point
module round_scheduler #(
  parameter int TICK_DIV     = 50000,
  parameter int WINDOW_TICKS = 100,
  parameter int ROUNDS       = 8,
  parameter int ROUND_W      = 4,
  parameter int SCORE_W      = 4
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iStart,
  input  logic               iStop,
  input  logic               iPaintDone,
  output logic               oEnableLFSM,
  output logic               oLoadPos,
  output logic               oPaintReq,
  output logic               oClearReq,
  output logic               oHit,
  output logic               oBusy,
  output logic               oGameOver,
  output logic [ROUND_W-1:0] oRound,
  output logic [SCORE_W-1:0] oScore
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int WW = $clog2(WINDOW_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_TICKS - 1);
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {IDLE, SEED, LOAD, PAINT, WAIT_HIT, CLEAR, NEXT, OVER} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tick;
  logic [WW-1:0] window;
  logic tick_wrap, expire;

  assign tick_wrap   = tick == TICK_LAST;
  assign expire      = tick_wrap && window == WIN_LAST;
  assign oEnableLFSM = state == IDLE || state == SEED;
  assign oLoadPos    = state == LOAD;
  assign oPaintReq   = state == PAINT;
  assign oClearReq   = state == CLEAR;
  assign oBusy       = state != IDLE && state != OVER;
  assign oGameOver   = state == OVER;

  // state register
  always_ff @(posedge iClk)
    state <= iReset ? IDLE : state_nx;

  // next-state logic; painter acks only count in PAINT and CLEAR
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = iStart ? SEED : IDLE;
      SEED:     state_nx = LOAD;
      LOAD:     state_nx = PAINT;
      PAINT:    state_nx = iPaintDone ? WAIT_HIT : PAINT;
      WAIT_HIT: state_nx = (iStop || expire) ? CLEAR : WAIT_HIT;
      CLEAR:    state_nx = iPaintDone ? NEXT : CLEAR;
      NEXT:     state_nx = oRound == ROUND_LAST ? OVER : LOAD;
      OVER:     state_nx = iStart ? SEED : OVER;
      default:  state_nx = IDLE;
    endcase
  end

  // round, score, reaction-window counters and hit pulse
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oRound <= '0;
      oScore <= '0;
      tick   <= '0;
      window <= '0;
      oHit   <= 1'b0;
    end else begin
      oHit <= state == WAIT_HIT && iStop;
      case (state)
        SEED: begin
          oRound <= '0;
          oScore <= '0;
        end
        PAINT: begin
          tick   <= '0;
          window <= '0;
        end
        WAIT_HIT: begin
          tick   <= tick_wrap ? '0 : tick + 1'b1;
          window <= tick_wrap ? window + 1'b1 : window;
          if (iStop)
            oScore <= oScore == SCORE_MAX ? oScore : oScore + 1'b1;
`ifdef MISS_PENALTY_EN
          else if (expire)
            oScore <= oScore == '0 ? oScore : oScore - 1'b1;
`endif
        end
        NEXT:
          oRound <= oRound == ROUND_LAST ? oRound : oRound + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_round_scheduler.sv
// tb_round_scheduler: randomized games checked by a scoreboard of expected load/clear/over events
module tb_round_scheduler;
  localparam int TD = 4, WT = 3, NR = 2, RW = 4, SW = 4;
  localparam int WINDOW = TD * WT;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stop = 1'b0, done = 1'b0;
  logic en_lfsm, load_pos, paint_req, clear_req, hit, busy, game_over;
  logic [RW-1:0] round;
  logic [SW-1:0] score;

  round_scheduler #(.TICK_DIV(TD), .WINDOW_TICKS(WT), .ROUNDS(NR), .ROUND_W(RW), .SCORE_W(SW)) dut (
    .iClk(clk), .iReset(rst), .iStart(start), .iStop(stop), .iPaintDone(done),
    .oEnableLFSM(en_lfsm), .oLoadPos(load_pos), .oPaintReq(paint_req), .oClearReq(clear_req),
    .oHit(hit), .oBusy(busy), .oGameOver(game_over), .oRound(round), .oScore(score)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int a; int b; int c; int d;} ev_t;
  ev_t exp_q[$];
  int npass = 0, ntotal = 0;

  task automatic check(input string name, input int act, input int expv);
    ntotal++;
    if (act == expv) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic push(input int kind, input int a, input int b, input int c, input int d);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int a, input int b, input int c, input int d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("ev_unexpected", kind, -1);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", kind, e.kind);
    check("ev_a", a, e.a);
    check("ev_b", b, e.b);
    check("ev_c", c, e.c);
    check("ev_d", d, e.d);
  endtask

  // monitor: kinds 0=LOAD(round,score) 1=CLEAR(offset,hit,score,round) 2=OVER(score,round,busy)
  logic prev_paint = 0, prev_clear = 0, prev_load = 0, prev_over = 0;
  int wcnt = 1000;
  always @(negedge clk) begin
    if (busy && prev_paint && !paint_req) wcnt = 0;
    else wcnt++;
    if (load_pos && !prev_load) observe(0, int'(round), int'(score), 0, 0);
    if (clear_req && !prev_clear) observe(1, wcnt, int'(hit), int'(score), int'(round));
    if (game_over && !prev_over) observe(2, int'(score), int'(round), int'(busy), 0);
    check("req_excl", int'(paint_req && clear_req), 0);
    check("hit_pulse", int'(hit && !(clear_req && !prev_clear)), 0);
    check("load_1cyc", int'(load_pos && prev_load), 0);
    check("load_to_paint", int'(prev_load && !paint_req), 0);
    check("over_busy", int'(game_over && busy), 0);
    check("lfsm_idle", int'(!busy && !game_over && !en_lfsm), 0);
    prev_paint = paint_req; prev_clear = clear_req; prev_load = load_pos; prev_over = game_over;
  end

  task automatic wait_paint();
    int n = 0;
    while (!paint_req && n < 50) begin
      stop = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check("paint_seen", int'(paint_req), 1);
  endtask

  // plays one game; stop offsets >= WINDOW mean the player never presses
  task automatic run_game(input int s0, input int s1, input bit abort);
    int s[2];
    int sc, off, d, n;
    bit h;
    s[0] = s0; s[1] = s1; sc = 0;
    for (int r = 0; r < NR; r++) begin
      push(0, r, sc, 0, 0);
      if (abort && r == 1) break;
      h = s[r] < WINDOW;
      off = h ? s[r] + 1 : WINDOW;
      if (h) sc = sc < SMAX ? sc + 1 : SMAX;
`ifdef MISS_PENALTY_EN
      else sc = sc > 0 ? sc - 1 : 0;
`endif
      push(1, off, int'(h), sc, r);
    end
    if (!abort) push(2, sc, NR - 1, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("seed", int'({busy, en_lfsm}), 3);
    for (int r = 0; r < NR; r++) begin
      wait_paint();
      if (abort && r == 1) begin
        stop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_paint", int'(paint_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_lfsm", int'(en_lfsm), 1);
        check("rst_score", int'(score), 0);
        check("rst_round", int'(round), 0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
        check("late_ack_paint", int'(paint_req), 0);
        check("late_ack_busy", int'(busy), 0);
        return;
      end
      d = $urandom_range(0, 3);
      repeat (d) begin
        stop = 1'($urandom);
        @(negedge clk);
      end
      stop = 1'b0;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      for (int j = 0; j < WINDOW + 2 && !clear_req; j++) begin
        stop = j == s[r];
        @(negedge clk);
      end
      stop = 1'b0;
      n = 0;
      while (!clear_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("clear_seen", int'(clear_req), 1);
      d = $urandom_range(0, 3);
      repeat (d) begin
        stop = 1'($urandom);
        start = 1'($urandom);
        @(negedge clk);
      end
      stop = 1'b0;
      start = 1'b0;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end
    n = 0;
    while (!game_over && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("over_seen", int'(game_over), 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("over_hold_score", int'(score), sc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_lfsm", int'(en_lfsm), 1);
    check("idle_load", int'(load_pos), 0);
    check("idle_paint", int'(paint_req), 0);
    check("idle_clear", int'(clear_req), 0);
    check("idle_hit", int'(hit), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_over", int'(game_over), 0);
    check("idle_score", int'(score), 0);
    check("idle_round", int'(round), 0);
    run_game(5, 99, 0);
    run_game(99, 99, 0);
    run_game(WINDOW - 1, WINDOW - 1, 0);
    run_game(0, 99, 0);
    run_game(99, 3, 0);
    run_game(2, 0, 1);
    for (int g = 0; g < 10; g++)
      run_game($urandom_range(0, WINDOW + 1), $urandom_range(0, WINDOW + 1), 0);
    repeat (3) @(negedge clk);
    check("evq_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
